// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg
// Shared definitions for blocks that sit on the NES CPU memory bus.
// Holds the common bus widths, the well-known register addresses used by
// the sprite DMA engine, and the DMA engine state type.
package nes_bus_pkg;

  // Common bus geometry for the CPU-side memory interface
  localparam int BUS_WIDTH_C      = 8;
  localparam int BUS_ADDR_WIDTH_C = 16;

  // CPU write to this address starts a sprite DMA; the written byte is the page
  localparam logic [15:0] DMA_REG_ADDR_C  = 16'h4014;
  // PPU OAM data port; every DMA byte is written here
  localparam logic [15:0] OAM_DATA_ADDR_C = 16'h2004;

  // Sprite DMA engine states
  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// oam_dma
// NES sprite DMA bus initiator. Snoops CPU writes for the DMA register; on a
// trigger it halts the CPU, takes the memory bus and copies XFER_LEN bytes
// from CPU page {page, 00h..} to the OAM data port, one read and one write
// per byte.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   cpu_we    CPU write strobe (snooped)
//   cpu_addr  CPU address (snooped)
//   cpu_din   CPU write data; the source page on a trigger
//   bus_din   read data returned from memory (valid while bus_we=0)
//   bus_req   DMA owns the bus; the top-level mux selects the DMA drivers
//   bus_addr  DMA bus address
//   bus_we    DMA write enable
//   bus_dout  DMA write data (0 outside WRITE)
//   cpu_halt  stalls the CPU core while a transfer is in progress
//   done      one-cycle pulse in the first IDLE cycle after a transfer
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter int                    WIDTH         = BUS_WIDTH_C,
  parameter int                    ADDR_WIDTH    = BUS_ADDR_WIDTH_C,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_C,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C,
  parameter int                    XFER_LEN      = 256,
  parameter int                    CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]      cpu_din,
  input  logic [WIDTH-1:0]      bus_din,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_we,
  output logic [WIDTH-1:0]      bus_dout,
  output logic                  cpu_halt,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(XFER_LEN - 1);

  dma_state_t           state;
  logic [WIDTH-1:0]     page;
  logic [WIDTH-1:0]     data_lat;
  logic [CNT_WIDTH-1:0] idx;
  logic                 cyc_odd;

  // Main sequencer. cyc_odd is a free-running parity bit; when HALT lands on
  // an odd cycle an extra ALIGN cycle is inserted so the read/write pairs
  // stay in step with the CPU's get/put cycles. idx is a plain wrapping
  // counter that never carries into page, so reads stay inside one page.
  // done is registered so it appears in the first IDLE cycle, which is also
  // a cycle where a new trigger is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      page     <= '0;
      idx      <= '0;
      data_lat <= '0;
      cyc_odd  <= 1'b0;
      done     <= 1'b0;
    end else begin
      cyc_odd <= ~cyc_odd;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
            page  <= cpu_din;
            idx   <= '0;
            state <= HALT;
          end
        end
        HALT: begin
          state <= cyc_odd ? ALIGN : READ;
        end
        ALIGN: begin
          state <= READ;
        end
        READ: begin
          data_lat <= bus_din;
          state    <= WRITE;
        end
        WRITE: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus drivers decoded straight from the registered state, so an async
  // reset drops every output in the same cycle it is asserted.
  always_comb begin
    bus_req  = (state != IDLE);
    cpu_halt = (state != IDLE);
    bus_we   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    unique case (state)
      READ: begin
        bus_addr = ADDR_WIDTH'({page, idx});
      end
      WRITE: begin
        bus_we   = 1'b1;
        bus_addr = OAM_DATA_ADDR;
        bus_dout = data_lat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma
// Self-checking bench for oam_dma. A memory model answers bus reads; every
// trigger pushes its expected OAM write stream and expected halt length into
// scoreboard queues, and a monitor on the falling edge pops and compares
// whenever the DUT writes or pulses done.
module tb_oam_dma;

  localparam int          XFER_LEN = 256;
  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA = 16'h2004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  bus_din;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [7:0]  bus_dout;
  logic        cpu_halt;
  logic        done;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] mem [0:65535];
  wr_t        expWrites[$];
  int         expHalt[$];
  int         checks = 0;
  int         passes = 0;
  int         haltCnt = 0;
  int         writesSeen = 0;
  int         cnt;

  oam_dma dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .bus_din  (bus_din),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_we   (bus_we),
    .bus_dout (bus_dout),
    .cpu_halt (cpu_halt),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Memory answers combinationally while the DMA is reading
  assign bus_din = bus_we ? 8'h00 : mem[bus_addr];

  // Posedges since reset release; its parity tells which trigger edge
  // leaves the DUT's parity bit odd during HALT
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 0;
    else       cnt <= cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Monitor: compares every DMA write and every done pulse against the
  // scoreboard, and checks that the bus is quiet whenever it is not owned
  always @(negedge clk) begin
    if (reset) begin
      expWrites.delete();
      expHalt.delete();
      haltCnt    = 0;
      writesSeen = 0;
    end else begin
      if (cpu_halt) haltCnt++;
      if (!bus_req) begin
        checkOutput("idle_bus", {bus_we, bus_addr, bus_dout}, 32'h0);
      end
      if (bus_we) begin
        if (expWrites.size() == 0) begin
          checkOutput("unexpected_write", 32'h1, 32'h0);
        end else begin
          wr_t w;
          w = expWrites.pop_front();
          checkOutput("wr_addr", bus_addr, w.addr);
          checkOutput("wr_data", bus_dout, w.data);
        end
        writesSeen++;
      end else if (bus_req) begin
        checkOutput("dout_not_write", bus_dout, 32'h0);
      end
      if (done) begin
        if (expHalt.size() == 0) begin
          checkOutput("spurious_done", 32'h1, 32'h0);
        end else begin
          int h;
          h = expHalt.pop_front();
          checkOutput("halt_cycles", haltCnt, h);
          checkOutput("write_count", writesSeen, XFER_LEN);
        end
        haltCnt    = 0;
        writesSeen = 0;
      end
    end
  end

  // Issue one trigger for the given page, choosing the trigger edge so the
  // ALIGN cycle is (or is not) needed; pushes the expected outcome first
  task automatic applyStimulus(input logic [7:0] page, input bit wantAlign);
    int guard;
    guard = 0;
    @(negedge clk);
    // Trigger edge k sees parity (k+1)%2 in HALT; ALIGN is taken when k is even
    while ((((cnt % 2) == 0) != wantAlign) && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < XFER_LEN; i++) begin
      wr_t w;
      w.addr = OAM_DATA;
      w.data = mem[{page, 8'(i)}];
      expWrites.push_back(w);
    end
    expHalt.push_back(1 + 2 * XFER_LEN + (wantAlign ? 1 : 0));
    cpu_we   = 1'b1;
    cpu_addr = DMA_REG;
    cpu_din  = page;
    @(negedge clk);
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
    checkOutput("halt_addr", {cpu_halt, bus_we, bus_addr}, {1'b1, 1'b0, 16'h0000});
    repeat (wantAlign ? 2 : 1) @(negedge clk);
    checkOutput("first_read", {bus_we, bus_addr}, {1'b0, page, 8'h00});
  endtask

  // Wait (bounded) for a given source read address to appear on the bus
  task automatic waitRead(input logic [15:0] addr);
    int guard;
    guard = 0;
    while (!(bus_req && !bus_we && bus_addr == addr) && guard < 1200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1200) checkOutput("wait_read_timeout", 32'h1, 32'h0);
  endtask

  // Wait (bounded) for every queued transfer to finish
  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((expHalt.size() != 0) && guard < 1200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1200) begin
      checkOutput("transfer_timeout", 32'h1, 32'h0);
      expHalt.delete();
      expWrites.delete();
    end
    repeat (3) @(negedge clk);
    checkOutput("left_writes", expWrites.size(), 32'h0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0000 + i] = 8'(i) ^ 8'h5A;
      mem[16'hFF00 + i] = 8'(i) ^ 8'hC3;
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_outputs", {bus_req, cpu_halt, bus_we, bus_addr, bus_dout, done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] aligned transfer from page 02");
    applyStimulus(8'h02, 1'b0);
    waitIdle();

    $display("[TB] odd alignment transfer from page 02");
    applyStimulus(8'h02, 1'b1);
    waitIdle();

    $display("[TB] retrigger while busy");
    applyStimulus(8'h02, 1'b0);
    waitRead(16'h020A);
    cpu_we   = 1'b1;
    cpu_addr = DMA_REG;
    cpu_din  = 8'h03;
    @(negedge clk);
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
    waitIdle();

    $display("[TB] non-matching write");
    @(negedge clk);
    cpu_we   = 1'b1;
    cpu_addr = 16'h4015;
    cpu_din  = 8'h07;
    @(negedge clk);
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
    repeat (3) begin
      checkOutput("nonmatch_idle", {bus_req, cpu_halt}, 32'h0);
      @(negedge clk);
    end

    $display("[TB] reset during write of byte 100");
    applyStimulus(8'h02, 1'($urandom_range(0, 1)));
    waitRead(16'h0264);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_outputs", {bus_req, cpu_halt, bus_we, bus_addr, bus_dout, done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("post_reset_quiet", {bus_req, done}, 32'h0);
    applyStimulus(8'h02, 1'b0);
    waitIdle();

    $display("[TB] top page FF");
    applyStimulus(8'hFF, 1'b0);
    waitIdle();

    $display("[TB] random pages");
    for (int t = 0; t < 3; t++) begin
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)));
      waitIdle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
